reveal_reader: RTL

//  Reader side of the guess-compare memory. After a compare pass writes match positions into
//  the dual-port RAM (addr POS_BASE downward), this block reads them back, updates the

---
 rtl/hangman_pkg.sv | 43 ++++
 rtl/reveal_mask.sv | 37 +++
 rtl/reveal_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared constants and types for the hangman guess/reveal datapath.
// Optional feature macro: REVEAL_ALL_EN (adds the walk states used by the lose screen).
package hangman_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CHAR_W = 5;

  // First (highest) address of the match-position list; the list grows downward.
  localparam logic [ADDR_W-1:0] POS_BASE = ADDR_W'(31);

  // Character code the display uses for an unrevealed slot.
  localparam logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(0);

`ifdef REVEAL_ALL_EN
  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdCap,
    StCheck,
    StDraw,
    StDone,
    StWalkReq,
    StWalkCap,
    StWalkDraw
  } state_e;
`else
  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdCap,
    StCheck,
    StDraw,
    StDone
  } state_e;
`endif

  // Valid word positions are 1..len; position 0 is never a letter slot.
  function automatic logic pos_in_range(input logic [ADDR_W-1:0] pos,
                                        input logic [ADDR_W-1:0] len);
    return (pos != '0) && (pos <= len);
  endfunction

endpackage

// File: rtl/reveal_mask.sv
// Revealed-letter mask plus count of letters still hidden in the current word.
module reveal_mask
  import hangman_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,      // synchronous, active-high
  input  logic              clr,
  input  logic [ADDR_W-1:0] len,
  input  logic              set,
  input  logic [ADDR_W-1:0] pos,
  output logic              already_set,
  output logic [ADDR_W-1:0] remaining
);

  logic [2**ADDR_W-1:0] r_mask;
  logic [ADDR_W-1:0]    r_remaining;

  // Mask bits and hidden-letter counter; counter saturates at zero.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_mask      <= '0;
      r_remaining <= '0;
    end else if (clr) begin
      r_mask      <= '0;
      r_remaining <= len;
    end else if (set) begin
      r_mask[pos] <= 1'b1;
      if (r_remaining != '0) begin
        r_remaining <= r_remaining - ADDR_W'(1);
      end
    end
  end

  assign already_set = r_mask[pos];
  assign remaining   = r_remaining;

endmodule

// File: rtl/reveal_reader.sv
// Reads match positions left by the compare pass, updates the reveal mask and issues one
// draw request per newly revealed position. Optional macro REVEAL_ALL_EN adds the
// reveal_all input, which walks every hidden position and draws the RAM character there.
module reveal_reader
  import hangman_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,      // synchronous, active-high despite the name
  input  logic              load_len,
  input  logic [ADDR_W-1:0] word_len,
  input  logic              start,
  input  logic [ADDR_W-1:0] match_count,
  input  logic [CHAR_W-1:0] guess,
`ifdef REVEAL_ALL_EN
  input  logic              reveal_all,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rd_data,
  output logic              draw_valid,
  input  logic              draw_ready,
  output logic [ADDR_W-1:0] draw_pos,
  output logic [CHAR_W-1:0] draw_char,
  output logic              busy,
  output logic              done,
  output logic              word_done,
  output logic              bad_pos
);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_len, w_len_d;
  logic [ADDR_W-1:0] r_n, w_n_d;
  logic [ADDR_W-1:0] r_idx, w_idx_d;
  logic [ADDR_W-1:0] r_pos, w_pos_d;
  logic [CHAR_W-1:0] r_char, w_char_d;
  logic              r_bad, w_bad_d;

  logic              w_mask_clr;
  logic              w_mask_set;
  logic [ADDR_W-1:0] w_mask_pos;
  logic              w_already;
  logic [ADDR_W-1:0] w_remaining;
  logic              w_more;

  reveal_mask u_mask (
    .clk         (clk),
    .resetn      (resetn),
    .clr         (w_mask_clr),
    .len         (word_len),
    .set         (w_mask_set),
    .pos         (w_mask_pos),
    .already_set (w_already),
    .remaining   (w_remaining)
  );

  // Another match position follows the current one.
  assign w_more = ({1'b0, r_idx} + (ADDR_W + 1)'(1)) < {1'b0, r_n};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_pos   <= '0;
      r_char  <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_n     <= w_n_d;
      r_idx   <= w_idx_d;
      r_pos   <= w_pos_d;
      r_char  <= w_char_d;
      r_bad   <= w_bad_d;
    end
  end

  // Next-state, datapath updates and per-state outputs.
  always_comb begin
    w_state_d  = r_state;
    w_len_d    = r_len;
    w_n_d      = r_n;
    w_idx_d    = r_idx;
    w_pos_d    = r_pos;
    w_char_d   = r_char;
    w_bad_d    = r_bad;
    w_mask_clr = 1'b0;
    w_mask_set = 1'b0;
    w_mask_pos = r_pos;
    rd_en      = 1'b0;
    rd_addr    = '0;
    draw_valid = 1'b0;
    draw_pos   = '0;
    draw_char  = '0;
    done       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (load_len) begin
          // load_len wins over any same-cycle start/reveal_all.
          w_len_d    = word_len;
          w_mask_clr = 1'b1;
          w_bad_d    = 1'b0;
`ifdef REVEAL_ALL_EN
        end else if (reveal_all) begin
          w_idx_d   = ADDR_W'(1);
          w_state_d = (r_len == '0) ? StDone : StWalkReq;
`endif
        end else if (start) begin
          w_char_d  = guess;
          w_n_d     = match_count;
          w_idx_d   = '0;
          w_state_d = (match_count == '0) ? StDone : StRdReq;
        end
      end

      StRdReq: begin
        rd_en     = 1'b1;
        rd_addr   = POS_BASE - r_idx;
        w_state_d = StRdCap;
      end

      StRdCap: begin
        w_pos_d   = rd_data;
        w_state_d = StCheck;
      end

      StCheck: begin
        if (!pos_in_range(r_pos, r_len) || w_already) begin
          if (!pos_in_range(r_pos, r_len)) begin
            w_bad_d = 1'b1;
          end
          if (w_more) begin
            w_idx_d   = r_idx + ADDR_W'(1);
            w_state_d = StRdReq;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_mask_set = 1'b1;
          w_state_d  = StDraw;
        end
      end

      StDraw: begin
        draw_valid = 1'b1;
        draw_pos   = r_pos;
        draw_char  = r_char;
        if (draw_ready) begin
          if (w_more) begin
            w_idx_d   = r_idx + ADDR_W'(1);
            w_state_d = StRdReq;
          end else begin
            w_state_d = StDone;
          end
        end
      end

      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end

`ifdef REVEAL_ALL_EN
      // Walk addresses 1..len; the RAM holds the word's character at each position.
      StWalkReq: begin
        rd_en      = 1'b1;
        rd_addr    = r_idx;
        w_mask_pos = r_idx;
        w_state_d  = StWalkCap;
      end

      StWalkCap: begin
        w_mask_pos = r_idx;
        w_char_d   = rd_data;
        if (w_already) begin
          if (r_idx < r_len) begin
            w_idx_d   = r_idx + ADDR_W'(1);
            w_state_d = StWalkReq;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_mask_set = 1'b1;
          w_state_d  = StWalkDraw;
        end
      end

      StWalkDraw: begin
        w_mask_pos = r_idx;
        draw_valid = 1'b1;
        draw_pos   = r_idx;
        draw_char  = r_char;
        if (draw_ready) begin
          if (r_idx < r_len) begin
            w_idx_d   = r_idx + ADDR_W'(1);
            w_state_d = StWalkReq;
          end else begin
            w_state_d = StDone;
          end
        end
      end
`endif

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign busy      = (r_state != StIdle);
  assign bad_pos   = r_bad;
  assign word_done = (w_remaining == '0) && (r_len != '0);

endmodule
